// File: rtl/note_ascii_fmt_pkg.sv
// Shared constants, state encoding and note-name lookup for the note formatter
// and for later display blocks built on the same note numbering.
package note_ascii_fmt_pkg;

    localparam logic [7:0] ascii_cr   = 8'h0D;
    localparam logic [7:0] ascii_lf   = 8'h0A;
    localparam logic [7:0] ascii_sp   = 8'h20;
    localparam logic [7:0] ascii_hash = 8'h23;
    localparam logic [7:0] ascii_dash = 8'h2D;
    localparam logic [7:0] ascii_zero = 8'h30;

    // Notes outside this range print as dashes (octave digit would leave 0..8).
    localparam logic [7:0] note_min = 8'd12;
    localparam logic [7:0] note_max = 8'd119;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_load = 2'd1,
        st_div  = 2'd2,
        st_send = 2'd3
    } fmt_state_t;

    // Pitch class 0..11 -> {ASCII letter, sharp flag}.
    function automatic logic [8:0] note_name(input logic [3:0] rem);
        logic [8:0] res;
        case (rem)
            4'd0:    res = {8'h43, 1'b0};
            4'd1:    res = {8'h43, 1'b1};
            4'd2:    res = {8'h44, 1'b0};
            4'd3:    res = {8'h44, 1'b1};
            4'd4:    res = {8'h45, 1'b0};
            4'd5:    res = {8'h46, 1'b0};
            4'd6:    res = {8'h46, 1'b1};
            4'd7:    res = {8'h47, 1'b0};
            4'd8:    res = {8'h47, 1'b1};
            4'd9:    res = {8'h41, 1'b0};
            4'd10:   res = {8'h41, 1'b1};
            4'd11:   res = {8'h42, 1'b0};
            default: res = {ascii_dash, 1'b0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/note_ascii_fmt_if.sv
// Byte stream towards the UART transmitter: data/valid from the formatter,
// ready back from the UART.
interface note_ascii_fmt_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/note_ascii_fmt_divmod12.sv
// Sequential divide-by-12: one subtraction per cycle after start.
// done is high on the cycle the remainder has dropped below 12; the
// division finishes on that edge. oct counts the subtractions performed.
module note_divmod12 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] note,
    output logic       done,
    output logic [3:0] rem,
    output logic [3:0] oct
);
    logic [6:0] rem_r;
    logic [3:0] oct_r;
    logic       busy_r;

    // Load on start, then subtract 12 per cycle until the remainder is final.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= 7'd0;
            oct_r  <= 4'd0;
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= note;
            oct_r  <= 4'd0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (rem_r >= 7'd12) begin
                rem_r <= rem_r - 7'd12;
                oct_r <= oct_r + 4'd1;
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign done = busy_r && (rem_r < 7'd12);
    assign rem  = rem_r[3:0];
    assign oct  = oct_r;

endmodule

// File: rtl/note_ascii_fmt.sv
// Turns each tuner note update into a short ASCII line ("A 4\r\n") and streams
// it byte by byte over a valid/ready link. One pending note is buffered so a
// strobe arriving while a line is in flight is not lost.
module note_ascii_fmt
    import note_ascii_fmt_pkg::*;
#(
    parameter bit dedup_p = 1'b1,
    parameter bit crlf_p  = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [7:0]       note_i,
    input  logic             update_i,
    note_ascii_fmt_if.master tx,
    output logic             busy_o,
    output logic             overrun_o
);
    localparam logic [2:0] last_idx = crlf_p ? 3'd4 : 3'd3;

    fmt_state_t state_r;
    logic [7:0] pend_note_r;
    logic       pend_full_r;
    logic [7:0] last_note_r;
    logic       last_vld_r;
    logic       valid_r;
    logic [7:0] data_r;
    logic [2:0] idx_r;
    logic [7:0] ch0_r;
    logic [7:0] ch1_r;
    logic [7:0] ch2_r;
    logic       overrun_r;

    logic       dup_s;
    logic       oor_s;
    logic       start_s;
    logic       div_done_s;
    logic [3:0] div_rem_s;
    logic [3:0] div_oct_s;
    logic [8:0] name_s;
    logic [7:0] digit_s;

    // Byte at a given line position; terminator depends on crlf_p.
    function automatic logic [7:0] byte_sel(input logic [2:0] idx, input logic [7:0] c0,
                                            input logic [7:0] c1, input logic [7:0] c2);
        logic [7:0] res;
        case (idx)
            3'd0:    res = c0;
            3'd1:    res = c1;
            3'd2:    res = c2;
            3'd3:    res = crlf_p ? ascii_cr : ascii_lf;
            default: res = ascii_lf;
        endcase
        return res;
    endfunction

    // Decode of the pending note: duplicate check, range check, divider start.
    always_comb begin
        dup_s = 1'b0;
        if (dedup_p && last_vld_r && (pend_note_r == last_note_r)) begin
            dup_s = 1'b1;
        end else begin
            dup_s = 1'b0;
        end
        oor_s   = (pend_note_r < note_min) || (pend_note_r > note_max);
        start_s = (state_r == st_load) && !dup_s && !oor_s;
        name_s  = note_name(div_rem_s);
        digit_s = ascii_zero + {4'd0, div_oct_s - 4'd1};
    end

    note_divmod12 u_divmod (
        .clk   (clk_i),
        .rst   (reset_i),
        .start (start_s),
        .note  (pend_note_r[6:0]),
        .done  (div_done_s),
        .rem   (div_rem_s),
        .oct   (div_oct_s)
    );

    // Pending slot, dedup memory and the line FSM with registered stream outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= st_idle;
            pend_note_r <= 8'h00;
            pend_full_r <= 1'b0;
            last_note_r <= 8'h00;
            last_vld_r  <= 1'b0;
            valid_r     <= 1'b0;
            data_r      <= 8'h00;
            idx_r       <= 3'd0;
            ch0_r       <= 8'h00;
            ch1_r       <= 8'h00;
            ch2_r       <= 8'h00;
            overrun_r   <= 1'b0;
        end else begin
            // A new strobe always wins over the consume in LOAD.
            overrun_r <= update_i && pend_full_r && (state_r != st_load);
            if (update_i) begin
                pend_note_r <= note_i;
                pend_full_r <= 1'b1;
            end else if (state_r == st_load) begin
                pend_full_r <= 1'b0;
            end

            case (state_r)
                st_idle: begin
                    if (pend_full_r) begin
                        state_r <= st_load;
                    end
                end
                st_load: begin
                    if (dup_s) begin
                        state_r <= st_idle;
                    end else begin
                        last_note_r <= pend_note_r;
                        last_vld_r  <= 1'b1;
                        if (oor_s) begin
                            ch0_r   <= ascii_dash;
                            ch1_r   <= ascii_dash;
                            ch2_r   <= ascii_dash;
                            data_r  <= ascii_dash;
                            valid_r <= 1'b1;
                            idx_r   <= 3'd0;
                            state_r <= st_send;
                        end else begin
                            state_r <= st_div;
                        end
                    end
                end
                st_div: begin
                    if (div_done_s) begin
                        ch0_r   <= name_s[8:1];
                        ch1_r   <= name_s[0] ? ascii_hash : ascii_sp;
                        ch2_r   <= digit_s;
                        data_r  <= name_s[8:1];
                        valid_r <= 1'b1;
                        idx_r   <= 3'd0;
                        state_r <= st_send;
                    end
                end
                st_send: begin
                    if (valid_r && tx.ready) begin
                        if (idx_r == last_idx) begin
                            valid_r <= 1'b0;
                            state_r <= st_idle;
                        end else begin
                            idx_r  <= idx_r + 3'd1;
                            data_r <= byte_sel(idx_r + 3'd1, ch0_r, ch1_r, ch2_r);
                        end
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= st_idle;
                end
            endcase
        end
    end

    assign tx.data   = data_r;
    assign tx.valid  = valid_r;
    assign overrun_o = overrun_r;
    assign busy_o    = (state_r != st_idle) || pend_full_r;

endmodule

// File: tb/tb_note_ascii_fmt.sv
// Directed bench for note_ascii_fmt: three instances (default, LF-only,
// dedup off), per-instance byte scoreboards filled from an arithmetic model.
module tb_note_ascii_fmt;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] note;
    logic       upd0, upd1, upd2;
    logic       rdy0;
    logic       busy0, busy1, busy2;
    logic       ovr0, ovr1, ovr2;

    int vectors = 0;
    int miscompares = 0;
    int ovr_cnt = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] e0, e1, e2;

    logic [7:0] letters [12] = '{8'h43, 8'h43, 8'h44, 8'h44, 8'h45, 8'h46,
                                 8'h46, 8'h47, 8'h47, 8'h41, 8'h41, 8'h42};
    bit         sharps  [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    note_ascii_fmt_if tx0 ();
    note_ascii_fmt_if tx1 ();
    note_ascii_fmt_if tx2 ();

    assign tx0.ready = rdy0;
    assign tx1.ready = 1'b1;
    assign tx2.ready = 1'b1;

    note_ascii_fmt #(.dedup_p(1'b1), .crlf_p(1'b1)) dut0 (
        .clk_i(clk), .reset_i(rst), .note_i(note), .update_i(upd0),
        .tx(tx0.master), .busy_o(busy0), .overrun_o(ovr0));
    note_ascii_fmt #(.dedup_p(1'b1), .crlf_p(1'b0)) dut1 (
        .clk_i(clk), .reset_i(rst), .note_i(note), .update_i(upd1),
        .tx(tx1.master), .busy_o(busy1), .overrun_o(ovr1));
    note_ascii_fmt #(.dedup_p(1'b0), .crlf_p(1'b1)) dut2 (
        .clk_i(clk), .reset_i(rst), .note_i(note), .update_i(upd2),
        .tx(tx2.master), .busy_o(busy2), .overrun_o(ovr2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line from note arithmetic; instance 1 is LF-only.
    task automatic expect_line(input int k, input int n);
        logic [7:0] b[$];
        int r, o;
        if (n < 12 || n > 119) begin
            b.push_back(8'h2D); b.push_back(8'h2D); b.push_back(8'h2D);
        end else begin
            r = n % 12;
            o = n / 12 - 1;
            b.push_back(letters[r]);
            b.push_back(sharps[r] ? 8'h23 : 8'h20);
            b.push_back(8'(8'h30 + o));
        end
        if (k != 1) b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[i]) begin
            case (k)
                0:       q0.push_back(b[i]);
                1:       q1.push_back(b[i]);
                default: q2.push_back(b[i]);
            endcase
        end
    endtask

    // Single-cycle update strobe; starts and ends just after a rising edge.
    task automatic pulse(input int k, input logic [7:0] n);
        note = n;
        case (k)
            0:       upd0 = 1'b1;
            1:       upd1 = 1'b1;
            default: upd2 = 1'b1;
        endcase
        @(posedge clk); #1;
        upd0 = 1'b0; upd1 = 1'b0; upd2 = 1'b0;
    endtask

    function automatic logic busy_of(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic wait_idle(input int k, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (busy_of(k) == 1'b0) break;
            @(posedge clk); #1;
        end
        check(tag, busy_of(k), 1'b0);
    endtask

    task automatic wait_valid0(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (tx0.valid == 1'b1) break;
            @(posedge clk); #1;
        end
        check(tag, tx0.valid, 1'b1);
    endtask

    // Byte scoreboards: every accepted byte must match the next expected one.
    always @(negedge clk) begin
        if (tx0.valid && tx0.ready) begin
            if (q0.size() == 0) check("k0_unexpected_byte", 32'(q0.size()), 32'd1);
            else begin e0 = q0.pop_front(); check("k0_byte", tx0.data, e0); end
        end
        if (tx1.valid && tx1.ready) begin
            if (q1.size() == 0) check("k1_unexpected_byte", 32'(q1.size()), 32'd1);
            else begin e1 = q1.pop_front(); check("k1_byte", tx1.data, e1); end
        end
        if (tx2.valid && tx2.ready) begin
            if (q2.size() == 0) check("k2_unexpected_byte", 32'(q2.size()), 32'd1);
            else begin e2 = q2.pop_front(); check("k2_byte", tx2.data, e2); end
        end
    end

    // Overrun pulse counter for the main instance.
    always @(negedge clk) begin
        if (ovr0 === 1'b1) ovr_cnt++;
    end

    initial begin
        int lat;
        int ovr_base;
        logic [7:0] first_b;

        rst = 1'b1; note = 8'h00; upd0 = 1'b0; upd1 = 1'b0; upd2 = 1'b0; rdy0 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_valid", tx0.valid, 1'b0);
        check("rst_data", tx0.data, 8'h00);
        check("rst_busy", busy0, 1'b0);
        check("rst_overrun", ovr0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // A4 with latency measurement
        expect_line(0, 69);
        pulse(0, 8'd69);
        lat = 0;
        while (!tx0.valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency_69", lat, 8);
        wait_idle(0, "idle_69");

        // C#3, then out-of-range low and high
        expect_line(0, 49);  pulse(0, 8'd49);  wait_idle(0, "idle_49");
        expect_line(0, 5);   pulse(0, 8'd5);   wait_idle(0, "idle_5");
        expect_line(0, 127); pulse(0, 8'd127); wait_idle(0, "idle_127");

        // Backpressure: hold ready low 100 cycles with the first byte presented
        rdy0 = 1'b0;
        expect_line(0, 45);
        first_b = q0[0];
        pulse(0, 8'd45);
        wait_valid0("bp_valid");
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", tx0.valid, 1'b1);
            check("bp_data_hold", tx0.data, first_b);
        end
        rdy0 = 1'b1;
        wait_idle(0, "idle_bp");

        // Dedup: 69, 69, 70 -> two lines
        expect_line(0, 69); pulse(0, 8'd69); wait_idle(0, "idle_d1");
        pulse(0, 8'd69); wait_idle(0, "idle_d2");
        expect_line(0, 70); pulse(0, 8'd70); wait_idle(0, "idle_d3");

        // Overrun: 62 parked while 60 is formatting, 64 overwrites it
        ovr_base = ovr_cnt;
        expect_line(0, 60);
        expect_line(0, 64);
        pulse(0, 8'd60);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse(0, 8'd62);
        pulse(0, 8'd64);
        wait_idle(0, "idle_ovr");
        check("overrun_pulses", ovr_cnt - ovr_base, 1);

        // Update landing on the LOAD edge is kept, no overrun
        ovr_base = ovr_cnt;
        expect_line(0, 67);
        expect_line(0, 71);
        pulse(0, 8'd67);
        @(posedge clk); #1;
        pulse(0, 8'd71);
        wait_idle(0, "idle_coinc");
        check("coinc_no_overrun", ovr_cnt - ovr_base, 0);

        // Random ready toggling across two lines
        expect_line(0, 50);
        pulse(0, 8'd50);
        for (int i = 0; i < 60; i++) begin
            rdy0 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        expect_line(0, 55);
        pulse(0, 8'd55);
        for (int i = 0; i < 80; i++) begin
            rdy0 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rdy0 = 1'b1;
        wait_idle(0, "idle_rand");

        // LF-only instance
        expect_line(1, 49); pulse(1, 8'd49); wait_idle(1, "idle_lf");

        // Dedup-off instance: three lines
        expect_line(2, 69); pulse(2, 8'd69); wait_idle(2, "idle_nd1");
        expect_line(2, 69); pulse(2, 8'd69); wait_idle(2, "idle_nd2");
        expect_line(2, 70); pulse(2, 8'd70); wait_idle(2, "idle_nd3");

        // Reset mid-SEND abandons the line; next update formats normally
        rdy0 = 1'b0;
        pulse(0, 8'd40);
        wait_valid0("rst_mid_valid");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_mid_valid_low", tx0.valid, 1'b0);
        check("rst_mid_data", tx0.data, 8'h00);
        check("rst_mid_busy", busy0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy0 = 1'b1;
        @(posedge clk); #1;
        expect_line(0, 40); pulse(0, 8'd40); wait_idle(0, "idle_after_rst");

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_ascii_fmt.md
Name: note_ascii_fmt

Overview:
Downstream of the tuner: converts each detected-note update into a short ASCII line and streams it byte-by-byte to uart_tx over a valid/ready handshake. Sits between the tuner outputs (note, update) and uart_tx (data, valid, ready). Buffers one pending note so pulse-style updates are never lost while a line is in flight.

Parameters:
dedup_p, 1, when 1 an update whose note equals the last formatted note is discarded
crlf_p, 1, line terminator: 1 = CR LF (5-byte line), 0 = LF only (4-byte line)

Ports:
clk_i  input  1  system clock
reset_i  input  1  reset; asynchronous, active-high
note_i  input  8  note number, MIDI numbering (69 = A4); sampled only when update_i=1
update_i  input  1  single-cycle strobe: note_i is a new result
data_o  output  8  ASCII byte to UART
valid_o  output  1  data_o valid
ready_i  input  1  UART accepts byte (transfer on valid_o & ready_i)
busy_o  output  1  1 whenever state != IDLE or pending is full
overrun_o  output  1  1-cycle pulse: a full pending slot was overwritten

Behaviour:
- Reset (async, immediate): state=IDLE, pending empty, last-sent flag cleared, valid_o=0, data_o=8'h00, busy_o=0, overrun_o=0. Reset mid-line abandons the line; no resume.
- Pending slot: on any edge with update_i=1, pending<=note_i and is marked full. If it was already full and not being consumed that cycle, overrun_o=1 next cycle. If set and consume happen in the same cycle, set wins (slot stays full with the new note).
- FSM states: IDLE, LOAD, DIV, SEND.
- IDLE: pending full -> LOAD.
- LOAD: consume pending into work reg, clear slot. If dedup_p and last-sent flag set and note == last note -> IDLE, no output. Else record last note and set the flag. If note < 12 or note > 119 -> SEND in dash mode. Else rem=note, oct=0 -> DIV.
- DIV: one subtraction per cycle: if rem >= 12 then rem -= 12, oct += 1; else -> SEND. Octave digit = oct-1 (0..8). Example: 69 takes 5 subtract cycles plus 1 exit cycle and gives rem=9, octave 4.
- SEND: byte index 0..4 (0..3 when crlf_p=0). Byte 0 = letter, byte 1 = '#' (0x23) for sharps or space (0x20) for naturals, byte 2 = '0'+octave, then 0x0D (if crlf_p), then 0x0A.
- Note names, rem 0..11: C C# D D# E F F# G G# A A# B.
- Dash mode: bytes 0..2 are '-' (0x2D), then the terminator.
- valid_o=1 throughout SEND. data_o is registered and held stable until valid_o & ready_i. The index advances only on that transfer. Transfer of the last byte -> IDLE, and valid_o drops in the same edge.
- Latency, idle block: update at edge t gives pending full at t. LOAD runs at t+1. First valid_o appears 2 + (DIV cycles) edges after t. For 69 that is t+8.
- No combinational path from ready_i to valid_o or data_o.

Decomposition:
- tuner_pkg holds:
  - ASCII constants: CR, LF, SP, HASH, DASH, ZERO.
  - Note range limits (12, 119).
  - A function mapping rem to {letter, sharp}.
  - State enum typedef.
- One sub-module, note_divmod12: a sequential divide-by-12 with start/done handshake, owning rem, oct and the DIV cycle. It is reusable for later display blocks.

Test Plan:
- update note 69, ready_i=1 -> bytes 0x41,0x20,0x34,0x0D,0x0A, valid_o first high 8 cycles after the update edge.
- note 49 -> 'C','#','3',CR,LF; with crlf_p=0 -> 'C','#','3',LF only.
- note 5, then note 127 -> each gives '-','-','-',CR,LF.
- dedup_p=1: 69, 69, 70 -> exactly two lines (A 4, A#4). With dedup_p=0 -> three lines.
- Backpressure: ready_i held low 100 cycles in SEND -> data_o and valid_o stable, no byte skipped or repeated. Also check random ready_i toggling.
- Overrun and reset:
  - Updates 60, 62, 64 during an active line -> overrun_o pulses once, the next line is for 64.
  - update_i coincident with LOAD -> the new note is retained.
  - reset_i asserted mid-SEND -> valid_o=0 immediately, the next update formats normally.
